// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with valid/ready handshake, status flags and iterative MUL/DIV.
// Build macro ALU_MULDIV_EN enables the shift-add multiplier and restoring divider.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Overflow
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           r_state;
  logic             r_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic             r_zero;
  logic             r_ovf;

  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  // Single-cycle results, computed straight from the inputs on the accepting edge.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (ALU_Sel)
      4'd0: begin
        {w_c, w_res} = {1'b0, A} + {1'b0, B};
        w_v = (A[WIDTH-1] == B[WIDTH-1]) && (w_res[WIDTH-1] != A[WIDTH-1]);
      end
      4'd1: begin
        w_res = A - B;
        w_c   = (A < B);
        w_v   = (A[WIDTH-1] != B[WIDTH-1]) && (w_res[WIDTH-1] != A[WIDTH-1]);
      end
      4'd2: w_c = 1'b1;
      4'd3: begin
`ifdef ALU_MULDIV_EN
        w_res = '1;
`endif
        w_c = 1'b1;
      end
      4'd4: begin w_res = {A[WIDTH-2:0], 1'b0};      w_c = A[WIDTH-1]; end
      4'd5: begin w_res = {1'b0, A[WIDTH-1:1]};      w_c = A[0];       end
      4'd6: begin w_res = {A[WIDTH-2:0], A[WIDTH-1]}; w_c = A[WIDTH-1]; end
      4'd7: begin w_res = {A[0], A[WIDTH-1:1]};      w_c = A[0];       end
      4'd8:  w_res = A & B;
      4'd9:  w_res = A | B;
      4'd10: w_res = A ^ B;
      4'd11: w_res = ~(A | B);
      4'd12: w_res = ~(A & B);
      4'd13: w_res = ~(A ^ B);
      4'd14: w_res = {{(WIDTH-1){1'b0}}, (A > B)};
      4'd15: w_res = {{(WIDTH-1){1'b0}}, (A == B)};
      default: ;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mhi;
  logic [WIDTH-1:0] w_mlo;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_dhi;
  logic [WIDTH-1:0] w_dlo;
  logic             w_last;
  logic             w_unused_msb;

  // r_hi/r_lo hold product halves for MUL and remainder/quotient for DIV.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_mhi   = w_sum[WIDTH:1];
  assign w_mlo   = {w_sum[0], r_lo[WIDTH-1:1]};
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_opnd});
  assign w_diff  = w_shift - {1'b0, r_opnd};
  assign w_dhi   = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_dlo   = {r_lo[WIDTH-2:0], w_ge};
  assign w_last  = (r_cnt == CW'(WIDTH-1));
  assign w_unused_msb = w_diff[WIDTH];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_out   <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef ALU_MULDIV_EN
      r_opnd  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
`ifdef ALU_MULDIV_EN
            r_hi  <= '0;
            r_cnt <= '0;
            if (ALU_Sel == 4'd2) begin
              r_opnd  <= A;
              r_lo    <= B;
              r_state <= S_MUL;
            end else if (ALU_Sel == 4'd3 && B != '0) begin
              r_opnd  <= B;
              r_lo    <= A;
              r_state <= S_DIV;
            end else
`endif
            begin
              r_out   <= w_res;
              r_carry <= w_c;
              r_zero  <= (w_res == '0);
              r_ovf   <= w_v;
              r_valid <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
`ifdef ALU_MULDIV_EN
        S_MUL: begin
          r_hi  <= w_mhi;
          r_lo  <= w_mlo;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_out   <= w_mlo;
            r_carry <= (w_mhi != '0);
            r_zero  <= (w_mlo == '0);
            r_ovf   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DIV: begin
          r_hi  <= w_dhi;
          r_lo  <= w_dlo;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_out   <= w_dlo;
            r_carry <= 1'b0;
            r_zero  <= (w_dlo == '0);
            r_ovf   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_valid;
  assign ALU_Out   = r_out;
  assign CarryOut  = r_carry;
  assign Zero      = r_zero;
  assign Overflow  = r_ovf;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq with a behavioural reference model.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   ALU_Sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALU_Out;
  logic         CarryOut;
  logic         Zero;
  logic         Overflow;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Out(ALU_Out), .CarryOut(CarryOut), .Zero(Zero), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cycle = 0;
  int   force_hold = 0;
  bit   outstanding = 0;
  bit   holding = 0;
  bit   expect_release = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  // Reference: plain arithmetic on the operation's meaning.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s);
    exp_t        e;
    logic [15:0] p;
    int          sa;
    int          sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    e.res = '0; e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.acc = 0;
    case (s)
      4'd0: begin p = 16'(a) + 16'(b); e.res = p[7:0]; e.c = p[8]; e.v = (sa + sb > 127) || (sa + sb < -128); end
      4'd1: begin e.res = a - b; e.c = (a < b); e.v = (sa - sb > 127) || (sa - sb < -128); end
`ifdef ALU_MULDIV_EN
      4'd2: begin p = 16'(a) * 16'(b); e.res = p[7:0]; e.c = (p[15:8] != 0); e.lat = 9; end
      4'd3: begin
        if (b == 0) begin e.res = 8'hFF; e.c = 1'b1; end
        else begin e.res = a / b; e.lat = 9; end
      end
`else
      4'd2, 4'd3: begin e.res = 8'h00; e.c = 1'b1; end
`endif
      4'd4: begin e.res = a << 1; e.c = a[7]; end
      4'd5: begin e.res = a >> 1; e.c = a[0]; end
      4'd6: begin e.res = (a << 1) | (a >> 7); e.c = a[7]; end
      4'd7: begin e.res = (a >> 1) | (a << 7); e.c = a[0]; end
      4'd8:  e.res = a & b;
      4'd9:  e.res = a | b;
      4'd10: e.res = a ^ b;
      4'd11: e.res = ~(a | b);
      4'd12: e.res = ~(a & b);
      4'd13: e.res = ~(a ^ b);
      4'd14: e.res = (a > b) ? 8'd1 : 8'd0;
      default: e.res = (a == b) ? 8'd1 : 8'd0;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] edges [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return 8'($urandom);
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s, input int hold);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got 0, expected 1 within 200 cycles");
      return;
    end
    force_hold = hold;
    A = a; B = b; ALU_Sel = s; in_valid = 1'b1;
    e = model(a, b, s);
    e.acc = cycle;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 8'($urandom); B = 8'($urandom); ALU_Sel = 4'($urandom);
    outstanding = 1'b1;
  endtask

  always @(posedge clk) cycle++;

  always @(posedge clk) begin
    #1;
    if (force_hold > 0) begin
      out_ready = 1'b0;
      force_hold--;
    end else begin
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (!holding) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got out_valid=1, expected no pending operation");
          end else begin
            cur = q.pop_front();
            holding = 1'b1;
            chk("latency", 32'(cycle - cur.acc), 32'(cur.lat));
          end
        end
        if (holding) begin
          chk("ALU_Out", 32'(ALU_Out), 32'(cur.res));
          chk("CarryOut", 32'(CarryOut), 32'(cur.c));
          chk("Zero", 32'(Zero), 32'(cur.z));
          chk("Overflow", 32'(Overflow), 32'(cur.v));
          chk("in_ready_done", 32'(in_ready), 32'd0);
          if (out_ready) begin
            holding = 1'b0;
            outstanding = 1'b0;
            expect_release = 1'b1;
          end
        end
      end else if (expect_release) begin
        chk("in_ready_release", 32'(in_ready), 32'd1);
        chk("ALU_Out_kept", 32'(ALU_Out), 32'(cur.res));
        expect_release = 1'b0;
      end else if (outstanding) begin
        chk("in_ready_busy", 32'(in_ready), 32'd0);
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; ALU_Sel = '0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ALU_Out", 32'(ALU_Out), 32'd0);
    chk("rst_flags", {29'd0, CarryOut, Zero, Overflow}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    issue(8'h0A, 8'h02, 4'd0, 0);
    issue(8'h02, 8'h0A, 4'd1, 0);
    issue(8'h7F, 8'h01, 4'd0, 0);
    issue(8'hAA, 8'hAA, 4'd10, 0);
    issue(8'hF6, 8'h0A, 4'd2, 0);
    issue(8'hF6, 8'h0A, 4'd3, 0);
    issue(8'h0A, 8'h00, 4'd3, 0);
    issue(8'h80, 8'h01, 4'd1, 0);
    issue(8'h33, 8'h44, 4'd0, 7);
    issue(8'h81, 8'h00, 4'd6, 0);
    issue(8'h81, 8'h00, 4'd7, 0);

    issue(8'h64, 8'h07, 4'd3, 0);
    repeat (3) @(posedge clk);
    #1;
    q.delete();
    outstanding = 1'b0; holding = 1'b0; expect_release = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_ALU_Out", 32'(ALU_Out), 32'd0);
    chk("midrst_flags", {29'd0, CarryOut, Zero, Overflow}, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1; rst = 1'b0;
    issue(8'h01, 8'h01, 4'd0, 0);

    for (int i = 0; i < 250; i++) begin
      issue(pick(), pick(), 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0) ? 4 : 0);
    end

    n = 0;
    while ((q.size() != 0 || outstanding || holding) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || outstanding || holding) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
